// File: rtl/fpau_pkg.sv
// Shared constants and helpers for the FP add/sub unit: default field widths and
// the derivation of the alignment-shift range.
package fpau_pkg;

  localparam int unsigned DefExpW = 8;
  localparam int unsigned DefManW = 23;
  localparam int unsigned DefGrs  = 3;

  // Smallest width able to hold values 0 .. value-1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

  // Largest useful alignment shift: hidden bit + fraction + guard/round/sticky.
  function automatic int unsigned sh_max(input int unsigned man_w, input int unsigned grs);
    return man_w + 1 + grs;
  endfunction

endpackage

// File: rtl/exp_diff_sat.sv
// Combinational exponent subtract: ordering, equality, saturated magnitude and far flag.
module exp_diff_sat import fpau_pkg::*; #(
  parameter int unsigned EXP_W  = DefExpW,
  parameter int unsigned SH_MAX = sh_max(DefManW, DefGrs),
  parameter int unsigned SH_W   = clog2(SH_MAX + 1)
) (
  input  logic [EXP_W-1:0] exp_a_i,
  input  logic [EXP_W-1:0] exp_b_i,
  output logic             a_lt_b_o,
  output logic             exp_eq_o,
  output logic [SH_W-1:0]  shift_o,
  output logic             far_o
);

  logic [EXP_W:0] diff;
  logic [EXP_W:0] mag;

  always_comb begin
    // One extra bit so the MSB is the borrow, i.e. exp_a < exp_b.
    diff     = {1'b0, exp_a_i} - {1'b0, exp_b_i};
    mag      = diff[EXP_W] ? (~diff + (EXP_W+1)'(1)) : diff;
    a_lt_b_o = diff[EXP_W];
    exp_eq_o = (diff == '0);
    far_o    = (64'(mag) >= 64'(SH_MAX));
    shift_o  = far_o ? SH_W'(SH_MAX) : SH_W'(mag);
  end

endmodule

// File: rtl/exp_align_pipe.sv
// Two-stage exponent compare / alignment stage with valid/ready handshake.
// S1 registers operands and the exponent difference, S2 orders the operands.
module exp_align_pipe import fpau_pkg::*; #(
  parameter  int unsigned EXP_W  = DefExpW,
  parameter  int unsigned MAN_W  = DefManW,
  parameter  int unsigned GRS    = DefGrs,
  localparam int unsigned SH_MAX = sh_max(MAN_W, GRS),
  localparam int unsigned SH_W   = clog2(SH_MAX + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [EXP_W-1:0] in_exp_a_i,
  input  logic [MAN_W:0]   in_man_a_i,
  input  logic [EXP_W-1:0] in_exp_b_i,
  input  logic [MAN_W:0]   in_man_b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [EXP_W-1:0] out_exp_big_o,
  output logic [MAN_W:0]   out_man_big_o,
  output logic [MAN_W:0]   out_man_small_o,
  output logic [SH_W-1:0]  out_shift_o,
  output logic             out_far_o,
  output logic             out_swap_o,
  output logic             out_exp_eq_o
);

  // Stage 1 state
  logic             s1_valid_q;
  logic [EXP_W-1:0] s1_exp_a_q, s1_exp_b_q;
  logic [MAN_W:0]   s1_man_a_q, s1_man_b_q;
  logic             s1_a_lt_b_q, s1_eq_q, s1_man_lt_q, s1_far_q;
  logic [SH_W-1:0]  s1_shift_q;

  // Stage 2 state (drives the outputs directly)
  logic             s2_valid_q;
  logic [EXP_W-1:0] s2_exp_big_q, s2_exp_big_d;
  logic [MAN_W:0]   s2_man_big_q, s2_man_big_d;
  logic [MAN_W:0]   s2_man_small_q, s2_man_small_d;
  logic             s2_swap_q, s2_swap_d;
  logic [SH_W-1:0]  s2_shift_q;
  logic             s2_far_q, s2_eq_q;

  logic             d_a_lt_b, d_eq, d_far;
  logic [SH_W-1:0]  d_shift;
  logic             s1_ready, s2_ready;

  // A stage may load when empty or when its content leaves this cycle.
  assign s2_ready   = ~s2_valid_q | out_ready_i;
  assign s1_ready   = ~s1_valid_q | s2_ready;
  assign in_ready_o = s1_ready;

  exp_diff_sat #(
    .EXP_W  (EXP_W),
    .SH_MAX (SH_MAX),
    .SH_W   (SH_W)
  ) u_exp_diff_sat (
    .exp_a_i  (in_exp_a_i),
    .exp_b_i  (in_exp_b_i),
    .a_lt_b_o (d_a_lt_b),
    .exp_eq_o (d_eq),
    .shift_o  (d_shift),
    .far_o    (d_far)
  );

  always_comb begin
    // Equal exponents fall back to the mantissa; an exact tie keeps A as big.
    s2_swap_d      = s1_a_lt_b_q | (s1_eq_q & s1_man_lt_q);
    s2_exp_big_d   = s2_swap_d ? s1_exp_b_q : s1_exp_a_q;
    s2_man_big_d   = s2_swap_d ? s1_man_b_q : s1_man_a_q;
    s2_man_small_d = s2_swap_d ? s1_man_a_q : s1_man_b_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q     <= 1'b0;
      s1_exp_a_q     <= '0;
      s1_exp_b_q     <= '0;
      s1_man_a_q     <= '0;
      s1_man_b_q     <= '0;
      s1_a_lt_b_q    <= 1'b0;
      s1_eq_q        <= 1'b0;
      s1_man_lt_q    <= 1'b0;
      s1_far_q       <= 1'b0;
      s1_shift_q     <= '0;
      s2_valid_q     <= 1'b0;
      s2_exp_big_q   <= '0;
      s2_man_big_q   <= '0;
      s2_man_small_q <= '0;
      s2_swap_q      <= 1'b0;
      s2_shift_q     <= '0;
      s2_far_q       <= 1'b0;
      s2_eq_q        <= 1'b0;
    end else begin
      if (s1_ready) begin
        s1_valid_q <= in_valid_i;
        if (in_valid_i) begin
          s1_exp_a_q  <= in_exp_a_i;
          s1_exp_b_q  <= in_exp_b_i;
          s1_man_a_q  <= in_man_a_i;
          s1_man_b_q  <= in_man_b_i;
          s1_a_lt_b_q <= d_a_lt_b;
          s1_eq_q     <= d_eq;
          s1_man_lt_q <= (in_man_a_i < in_man_b_i);
          s1_far_q    <= d_far;
          s1_shift_q  <= d_shift;
        end
      end
      if (s2_ready) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_exp_big_q   <= s2_exp_big_d;
          s2_man_big_q   <= s2_man_big_d;
          s2_man_small_q <= s2_man_small_d;
          s2_swap_q      <= s2_swap_d;
          s2_shift_q     <= s1_shift_q;
          s2_far_q       <= s1_far_q;
          s2_eq_q        <= s1_eq_q;
        end
      end
    end
  end

  assign out_valid_o     = s2_valid_q;
  assign out_exp_big_o   = s2_exp_big_q;
  assign out_man_big_o   = s2_man_big_q;
  assign out_man_small_o = s2_man_small_q;
  assign out_shift_o     = s2_shift_q;
  assign out_far_o       = s2_far_q;
  assign out_swap_o      = s2_swap_q;
  assign out_exp_eq_o    = s2_eq_q;

endmodule

// File: tb/tb_exp_align_pipe.sv
// Bench for exp_align_pipe: directed vector table and handshake sequences on the
// default 8/23 configuration, randomized scoreboard run on an 11/52 configuration.
module tb_exp_align_pipe;

  logic clk;
  logic rst;

  // Narrow instance (EXP_W=8, MAN_W=23, SH_MAX=27, SH_W=5)
  logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [7:0]  n_ea, n_eb, n_exp_big;
  logic [23:0] n_ma, n_mb, n_man_big, n_man_small;
  logic [4:0]  n_shift;
  logic        n_far, n_swap, n_eq;

  // Wide instance (EXP_W=11, MAN_W=52, SH_MAX=56, SH_W=6)
  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [10:0] w_ea, w_eb, w_exp_big;
  logic [52:0] w_ma, w_mb, w_man_big, w_man_small;
  logic [5:0]  w_shift;
  logic        w_far, w_swap, w_eq;

  int checks = 0;
  int errors = 0;

  exp_align_pipe u_narrow (
    .clk_i           (clk),
    .rst_i           (rst),
    .in_valid_i      (n_in_valid),
    .in_ready_o      (n_in_ready),
    .in_exp_a_i      (n_ea),
    .in_man_a_i      (n_ma),
    .in_exp_b_i      (n_eb),
    .in_man_b_i      (n_mb),
    .out_valid_o     (n_out_valid),
    .out_ready_i     (n_out_ready),
    .out_exp_big_o   (n_exp_big),
    .out_man_big_o   (n_man_big),
    .out_man_small_o (n_man_small),
    .out_shift_o     (n_shift),
    .out_far_o       (n_far),
    .out_swap_o      (n_swap),
    .out_exp_eq_o    (n_eq)
  );

  exp_align_pipe #(
    .EXP_W (11),
    .MAN_W (52),
    .GRS   (3)
  ) u_wide (
    .clk_i           (clk),
    .rst_i           (rst),
    .in_valid_i      (w_in_valid),
    .in_ready_o      (w_in_ready),
    .in_exp_a_i      (w_ea),
    .in_man_a_i      (w_ma),
    .in_exp_b_i      (w_eb),
    .in_man_b_i      (w_mb),
    .out_valid_o     (w_out_valid),
    .out_ready_i     (w_out_ready),
    .out_exp_big_o   (w_exp_big),
    .out_man_big_o   (w_man_big),
    .out_man_small_o (w_man_small),
    .out_shift_o     (w_shift),
    .out_far_o       (w_far),
    .out_swap_o      (w_swap),
    .out_exp_eq_o    (w_eq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [63:0] exp_big;
    logic [63:0] man_big;
    logic [63:0] man_small;
    logic [63:0] shift;
    logic        far;
    logic        swap;
    logic        eq;
  } res_t;

  typedef struct {
    logic [7:0]  ea;
    logic [23:0] ma;
    logic [7:0]  eb;
    logic [23:0] mb;
    logic [7:0]  big;
    logic [23:0] mbig;
    logic [23:0] msmall;
    logic [4:0]  sh;
    logic        far;
    logic        swap;
    logic        eq;
  } vec_t;

  // Reference: the larger magnitude wins, the gap is clipped at shmax.
  function automatic res_t model(input longint unsigned ea, input longint unsigned ma,
                                 input longint unsigned eb, input longint unsigned mb,
                                 input longint unsigned shmax);
    res_t r;
    longint unsigned gap;
    r.swap      = (eb > ea) || ((eb == ea) && (mb > ma));
    r.exp_big   = r.swap ? eb : ea;
    r.man_big   = r.swap ? mb : ma;
    r.man_small = r.swap ? ma : mb;
    gap         = (ea > eb) ? (ea - eb) : (eb - ea);
    r.far       = (gap >= shmax);
    r.shift     = (gap > shmax) ? shmax : gap;
    r.eq        = (ea == eb);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_n(input string tag, input res_t e);
    chk({tag, ".exp_big"},   64'(n_exp_big),   e.exp_big);
    chk({tag, ".man_big"},   64'(n_man_big),   e.man_big);
    chk({tag, ".man_small"}, 64'(n_man_small), e.man_small);
    chk({tag, ".shift"},     64'(n_shift),     e.shift);
    chk({tag, ".far"},       64'(n_far),       64'(e.far));
    chk({tag, ".swap"},      64'(n_swap),      64'(e.swap));
    chk({tag, ".exp_eq"},    64'(n_eq),        64'(e.eq));
  endtask

  task automatic chk_w(input string tag, input res_t e);
    chk({tag, ".exp_big"},   64'(w_exp_big),   e.exp_big);
    chk({tag, ".man_big"},   64'(w_man_big),   e.man_big);
    chk({tag, ".man_small"}, 64'(w_man_small), e.man_small);
    chk({tag, ".shift"},     64'(w_shift),     e.shift);
    chk({tag, ".far"},       64'(w_far),       64'(e.far));
    chk({tag, ".swap"},      64'(w_swap),      64'(e.swap));
    chk({tag, ".exp_eq"},    64'(w_eq),        64'(e.eq));
  endtask

  // Single pair through an empty pipe; checks the 2-cycle latency and the result.
  task automatic run_vec(input vec_t v, input int idx);
    res_t e;
    string tag;
    tag = $sformatf("vec%0d", idx);
    e.exp_big = 64'(v.big); e.man_big = 64'(v.mbig); e.man_small = 64'(v.msmall);
    e.shift = 64'(v.sh); e.far = v.far; e.swap = v.swap; e.eq = v.eq;
    n_out_ready = 1'b1;
    n_in_valid  = 1'b1;
    n_ea = v.ea; n_ma = v.ma; n_eb = v.eb; n_mb = v.mb;
    #1;
    chk({tag, ".in_ready"}, 64'(n_in_ready), 64'd1);
    @(posedge clk); #1;
    n_in_valid = 1'b0;
    n_ea = '1; n_ma = '1; n_eb = '0; n_mb = '0;
    chk({tag, ".valid_c1"}, 64'(n_out_valid), 64'd0);
    @(posedge clk); #1;
    chk({tag, ".valid_c2"}, 64'(n_out_valid), 64'd1);
    chk_n(tag, e);
    @(posedge clk); #1;
    chk({tag, ".valid_c3"}, 64'(n_out_valid), 64'd0);
  endtask

  vec_t tbl[10];
  logic [7:0]  bp_ea[8], bp_eb[8];
  logic [23:0] bp_ma[8], bp_mb[8];
  res_t        bp_exp[8];
  res_t        scb[$];

  initial begin
    int acc, got, extra;
    logic fire;
    res_t e;
    int unsigned mode;
    int signed dlt;

    tbl[0] = '{8'h85, 24'h800000, 8'h80, 24'h800000, 8'h85, 24'h800000, 24'h800000, 5'd5,  1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'h7F, 24'hA00000, 8'h9A, 24'h900000, 8'h9A, 24'h900000, 24'hA00000, 5'd27, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 24'h800000, 8'hFF, 24'hFFFFFF, 8'hFF, 24'hFFFFFF, 24'h800000, 5'd27, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{8'h90, 24'h800001, 8'h90, 24'hC00000, 8'h90, 24'hC00000, 24'h800001, 5'd0,  1'b0, 1'b1, 1'b1};
    tbl[4] = '{8'h90, 24'hABCDEF, 8'h90, 24'hABCDEF, 8'h90, 24'hABCDEF, 24'hABCDEF, 5'd0,  1'b0, 1'b0, 1'b1};
    tbl[5] = '{8'h9A, 24'h812345, 8'h80, 24'hFFFFFF, 8'h9A, 24'h812345, 24'hFFFFFF, 5'd26, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{8'hFF, 24'hC00000, 8'h00, 24'h800000, 8'hFF, 24'hC00000, 24'h800000, 5'd27, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{8'h80, 24'h800000, 8'h9C, 24'h900000, 8'h9C, 24'h900000, 24'h800000, 5'd27, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{8'h81, 24'h800000, 8'h80, 24'hFFFFFF, 8'h81, 24'h800000, 24'hFFFFFF, 5'd1,  1'b0, 1'b0, 1'b0};
    tbl[9] = '{8'h40, 24'hC00001, 8'h40, 24'hC00000, 8'h40, 24'hC00001, 24'hC00000, 5'd0,  1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    n_in_valid = 1'b0; n_out_ready = 1'b1; n_ea = '0; n_eb = '0; n_ma = '0; n_mb = '0;
    w_in_valid = 1'b0; w_out_ready = 1'b1; w_ea = '0; w_eb = '0; w_ma = '0; w_mb = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    e = '{64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0};
    chk("reset.out_valid", 64'(n_out_valid), 64'd0);
    chk("reset.in_ready", 64'(n_in_ready), 64'd1);
    chk_n("reset", e);
    chk("reset.w_out_valid", 64'(w_out_valid), 64'd0);

    for (int i = 0; i < 10; i++) run_vec(tbl[i], i);

    // Backpressure: downstream stalled for the first 4 cycles, 8 pairs streamed.
    for (int i = 0; i < 8; i++) begin
      bp_ea[i] = 8'($urandom_range(100, 140));
      bp_eb[i] = 8'($urandom_range(100, 140));
      bp_ma[i] = {1'b1, 23'($urandom)};
      bp_mb[i] = {1'b1, 23'($urandom)};
      bp_exp[i] = model(64'(bp_ea[i]), 64'(bp_ma[i]), 64'(bp_eb[i]), 64'(bp_mb[i]), 27);
    end
    acc = 0; got = 0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      n_out_ready = (cyc >= 4);
      n_in_valid  = (acc < 8);
      if (acc < 8) begin
        n_ea = bp_ea[acc]; n_ma = bp_ma[acc]; n_eb = bp_eb[acc]; n_mb = bp_mb[acc];
      end
      #1;
      if (cyc == 2 || cyc == 3) begin
        chk("bp.in_ready_low", 64'(n_in_ready), 64'd0);
        chk("bp.accepts", 64'(acc), 64'd2);
        chk("bp.hold_valid", 64'(n_out_valid), 64'd1);
        chk_n("bp.hold", bp_exp[0]);
      end
      if (n_out_valid && n_out_ready) begin
        if (got < 8) chk_n($sformatf("bp.out%0d", got), bp_exp[got]);
        got++;
      end
      fire = n_in_valid && n_in_ready;
      @(posedge clk); #1;
      if (fire) acc++;
    end
    chk("bp.count", 64'(got), 64'd8);
    n_in_valid = 1'b0;
    extra = 0;
    repeat (4) begin
      if (n_out_valid) extra++;
      @(posedge clk); #1;
    end
    chk("bp.no_duplicate", 64'(extra), 64'd0);

    // Reset with both stages full.
    n_out_ready = 1'b0;
    n_in_valid  = 1'b1;
    repeat (2) begin
      n_ea = 8'($urandom); n_ma = {1'b1, 23'($urandom)};
      n_eb = 8'($urandom); n_mb = {1'b1, 23'($urandom)};
      @(posedge clk); #1;
    end
    n_in_valid = 1'b0;
    chk("rst.full_in_ready", 64'(n_in_ready), 64'd0);
    chk("rst.full_valid", 64'(n_out_valid), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst.out_valid", 64'(n_out_valid), 64'd0);
    chk("rst.in_ready", 64'(n_in_ready), 64'd1);
    chk_n("rst", e);
    n_out_ready = 1'b1;
    extra = 0;
    repeat (5) begin
      if (n_out_valid) extra++;
      @(posedge clk); #1;
    end
    chk("rst.no_stale", 64'(extra), 64'd0);

    // Randomized run on the wide instance with toggling valid/ready.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      w_out_ready = ($urandom_range(0, 3) != 0);
      w_in_valid  = (cyc < 2800) && ($urandom_range(0, 2) != 0);
      mode = $urandom_range(0, 3);
      w_ea = 11'($urandom);
      w_ma = {1'b1, 20'($urandom), 32'($urandom)};
      w_mb = {1'b1, 20'($urandom), 32'($urandom)};
      if (mode == 0) begin
        w_eb = 11'($urandom);
      end else if (mode == 1) begin
        dlt = $urandom_range(0, 140) - 70;
        if (int'(w_ea) + dlt < 0) w_eb = 11'd0;
        else if (int'(w_ea) + dlt > 2047) w_eb = 11'd2047;
        else w_eb = 11'(int'(w_ea) + dlt);
      end else begin
        w_eb = w_ea;
        if (mode == 3) w_mb = w_ma;
      end
      #1;
      if (w_out_valid && w_out_ready) begin
        if (scb.size() == 0) begin
          chk("rnd.spurious_output", 64'd1, 64'd0);
        end else begin
          e = scb.pop_front();
          chk_w("rnd", e);
        end
      end
      if (w_in_valid && w_in_ready) scb.push_back(model(64'(w_ea), 64'(w_ma), 64'(w_eb),
                                                        64'(w_mb), 56));
      @(posedge clk); #1;
    end
    chk("rnd.drained", 64'(scb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
